mmio_timer_peripheral: RTL and testbench
========================================

Name: mmio_timer_peripheral

Overview:
- Memory-mapped I/O responder on the CPU data bus, sitting beside the data memory. It decodes a 32-byte window at BASE_ADDR.
- Responds to the CPU's load/store requests (Address, Write_data, MemRead, MemWrite) with read data.
- Implements a reloadable overflow timer with interrupt, a free-running systick counter, LED and 7-segment output registers, and an optional UART transmitter.

Parameters:
- BASE_ADDR, 32'h4000_0000, window base; must be 32-byte aligned.
- CLKS_PER_BIT, 16, UART bit period in clk cycles; used only with MMIO_UART_TX_EN.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- Address  in  32  byte address from the CPU
- Write_data  in  32  store data
- MemRead  in  1  load request, combinational read
- MemWrite  in  1  store request, committed on the clk edge
- Read_data  out  32  load data, combinational
- hit  out  1  Address lies inside the window
- irq  out  1  timer interrupt request
- leds  out  8  LED register
- digi  out  12  7-segment register
- uart_txd  out  1  serial TX line, idle high

Behaviour:
- Decode:
  - hit = (Address[31:5] == BASE_ADDR[31:5]).
  - offset = Address[4:2]; Address[1:0] is ignored.
- Register map (offset x4):
  - 0 TH, reload value.
  - 1 TL, counter.
  - 2 TCON[2:0]: bit0 enable, bit1 irq enable, bit2 status.
  - 3 LED[7:0].
  - 4 DIGI[11:0].
  - 5 SYSTICK, read-only.
  - 6 UTX[7:0], write-only.
  - 7 USTAT: bit0 busy.
- Reads:
  - Read_data = selected register, zero-extended, when MemRead & hit; otherwise 32'h0.
  - Zero latency. Write-only and unmapped registers read 0.
- Writes: take effect at the clk edge when MemWrite & hit. Writes to read-only offsets are ignored.
- Reset (reset=0, async): TH, TL, TCON, LED, DIGI, SYSTICK = 0; irq = 0; uart_txd = 1; UART FSM = IDLE.
- Timer, each edge with TCON[0]=1:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and if TCON[1]=1 set TCON[2].
  - Otherwise TL <= TL + 1.
- irq = TCON[1] & TCON[2], registered-state derived with no extra delay.
- Simultaneous events:
  - CPU write to TL in the same edge as an overflow: the CPU value wins and there is no reload. Status is still set, because overflow is detected on the pre-write TL.
  - CPU write to TCON clearing bit2 in the same edge as a new overflow: bit2 ends at 1, so no event is lost. Bits 1:0 take the written value.
  - Write to TCON with bit0=0: TL freezes from the next edge.
- SYSTICK: increments by 1 every edge unconditionally; wraps from FFFF_FFFF to 0.
- Store data truncation: LED takes Write_data[7:0]; DIGI takes Write_data[11:0]; TCON takes Write_data[2:0].

Optional Feature:
- MMIO_UART_TX_EN defined: the UART transmitter is built.
  - A write to UTX while USTAT.busy=0 latches the byte and sets busy the next edge.
  - FSM: IDLE -> START (txd=0) -> DATA (8 bits, LSB first) -> STOP (txd=1) -> IDLE. Each state lasts CLKS_PER_BIT cycles.
  - busy clears on the edge that returns to IDLE.
  - A write to UTX while busy=1 is dropped silently.
  - Reset mid-frame aborts the frame: txd=1, IDLE.
- MMIO_UART_TX_EN undefined:
  - No UART logic; uart_txd tied 1.
  - Offsets 6 and 7 read 0; writes to them are ignored.

Test Plan:
- Reset released, then read offset 5 after 10 edges -> Read_data = 10. Read offsets 0-4 -> all 0; uart_txd = 1.
- Write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3'b011 -> TL reads FFFF_FFFF after 1 edge. After the 2nd edge: TL = FFFF_FFF0, TCON = 3'b111, irq = 1.
- Overflow edge coincides with a TCON write of 3'b011 -> TCON reads 3'b111 and irq stays 1. A subsequent lone write of 3'b011 -> irq = 0.
- Address 32'h4000_0020 store of 5 with MemWrite=1 -> hit = 0, LED unchanged. Store 32'h1234_56A5 to 32'h4000_000C -> leds = 8'hA5.
- Async reset pulse mid-count, without a clk edge -> TL, TCON, irq, leds, digi read 0 immediately.
- (MMIO_UART_TX_EN, CLKS_PER_BIT=4) write UTX=8'h55 -> txd holds each of 0,1,0,1,0,1,0,1,0,1 for 4 cycles, busy for 40 cycles. A second write during busy produces no second frame.

Source files
------------

// File: rtl/mmio_timer_peripheral_if.sv
// CPU data-bus bundle for the MMIO timer peripheral.
// The CPU side uses the master modport and the peripheral uses the slave modport.
interface mmio_timer_peripheral_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        hit;

  modport master (
    output Address, Write_data, MemRead, MemWrite,
    input  Read_data, hit
  );

  modport slave (
    input  Address, Write_data, MemRead, MemWrite,
    output Read_data, hit
  );
endinterface

// File: rtl/mmio_timer_peripheral.sv
// This file provides a 32-byte MMIO window containing a reloadable overflow timer with an interrupt, a systick counter, and LED and 7-segment registers.
// The optional UART transmitter is built only when MMIO_UART_TX_EN is defined.
module mmio_timer_peripheral #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_timer_peripheral_if.slave bus,
  output logic                   irq,
  output logic [7:0]             leds,
  output logic [11:0]            digi,
  output logic                   uart_txd
);

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGI    = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;
  localparam logic [2:0] OFF_UTX     = 3'd6;
  localparam logic [2:0] OFF_USTAT   = 3'd7;

  logic        hitWin;
  logic [2:0]  offset;
  logic        wrEn;
  logic        overflow;
  logic        uartBusy;
  logic        unusedAddrBits;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] systick_q;
  logic [31:0] rdata;

  assign hitWin         = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign offset         = bus.Address[4:2];
  assign wrEn           = bus.MemWrite & hitWin;
  assign unusedAddrBits = ^bus.Address[1:0];

  assign bus.hit = hitWin;
  assign irq     = tcon_q[1] & tcon_q[2];
  assign leds    = led_q;
  assign digi    = digi_q;

  // Overflow is judged on the pre-write TL, so a CPU store to TL or TCON on the
  // overflow edge still records the status event.
  always_comb begin
    th_d     = th_q;
    tl_d     = tl_q;
    tcon_d   = tcon_q;
    led_d    = led_q;
    digi_d   = digi_q;
    overflow = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    if (tcon_q[0]) begin
      tl_d = overflow ? th_q : tl_q + 32'd1;
    end
    tcon_d[2] = tcon_q[2] | (overflow & tcon_q[1]);
    if (wrEn) begin
      case (offset)
        OFF_TH:   th_d   = bus.Write_data;
        OFF_TL:   tl_d   = bus.Write_data;
        OFF_TCON: tcon_d = {bus.Write_data[2] | (overflow & tcon_q[1]), bus.Write_data[1:0]};
        OFF_LED:  led_d  = bus.Write_data[7:0];
        OFF_DIGI: digi_d = bus.Write_data[11:0];
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      tcon_q    <= '0;
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_q + 32'd1;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.MemRead && hitWin) begin
      case (offset)
        OFF_TH:      rdata = th_q;
        OFF_TL:      rdata = tl_q;
        OFF_TCON:    rdata = {29'd0, tcon_q};
        OFF_LED:     rdata = {24'd0, led_q};
        OFF_DIGI:    rdata = {20'd0, digi_q};
        OFF_SYSTICK: rdata = systick_q;
        OFF_USTAT:   rdata = {31'd0, uartBusy};
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.Read_data = rdata;

`ifdef MMIO_UART_TX_EN
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uartState_t;

  uartState_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bitIdx_q, bitIdx_d;
  logic [7:0]        shift_q, shift_d;
  logic              bitDone;

  assign uartBusy = (state_q != UART_IDLE);

  // Each frame phase lasts one bit period and the data bits shift out LSB first.
  // A store while a frame is in flight is simply ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    bitDone  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    if (state_q != UART_IDLE) begin
      cnt_d = bitDone ? '0 : cnt_q + CNT_W'(1);
    end
    case (state_q)
      UART_IDLE: begin
        if (wrEn && (offset == OFF_UTX)) begin
          state_d  = UART_START;
          shift_d  = bus.Write_data[7:0];
          cnt_d    = '0;
          bitIdx_d = '0;
        end
      end
      UART_START: if (bitDone) state_d = UART_DATA;
      UART_DATA: begin
        if (bitDone) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      UART_STOP: if (bitDone) state_d = UART_IDLE;
      default:   state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= UART_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    uart_txd = 1'b1;
    case (state_q)
      UART_START: uart_txd = 1'b0;
      UART_DATA:  uart_txd = shift_q[0];
      default:    uart_txd = 1'b1;
    endcase
  end
`else
  localparam int unsigned unusedClksPerBit = CLKS_PER_BIT;

  assign uartBusy = 1'b0;
  assign uart_txd = 1'b1;
`endif

endmodule

// File: tb/tb_mmio_timer_peripheral.sv
// This is a self-checking bench for mmio_timer_peripheral.
// It applies directed and randomized bus traffic and compares the results against a register-level reference model.
module tb_mmio_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          CLKS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        uart_txd;

  int checks = 0;
  int errors = 0;

  logic [31:0] mTh, mTl, mTick;
  logic [2:0]  mTcon;
  logic [7:0]  mLed;
  logic [11:0] mDigi;

  logic [9:0]  frame;
  logic [2:0]  rOff;
  logic [31:0] rAddr, rData;
  logic        rWe;

  mmio_timer_peripheral_if bus();

  mmio_timer_peripheral #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .irq(irq),
    .leds(leds),
    .digi(digi),
    .uart_txd(uart_txd)
  );

  // The clock has a 10-time-unit period, so rising edges occur at 5, 15, 25 and so on.
  always #5 clk = ~clk;

  // The watchdog guarantees that the run terminates even if the stimulus stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mTh = '0; mTl = '0; mTcon = '0; mLed = '0; mDigi = '0; mTick = '0;
  endtask

  // The reference model applies one clock edge using the register-map rules.
  // Counter wrap is taken from the carry out of a 33-bit increment.
  task automatic modelEdge(input logic [31:0] a, input logic [31:0] d, input logic we);
    logic [32:0] bumped;
    logic        wrapped;
    logic        statusEvent;
    logic [31:0] nextTl;
    logic [2:0]  nextTcon;
    bumped      = {1'b0, mTl} + 33'd1;
    wrapped     = mTcon[0] && bumped[32];
    statusEvent = wrapped && mTcon[1];
    nextTl      = !mTcon[0] ? mTl : (wrapped ? mTh : bumped[31:0]);
    nextTcon    = {mTcon[2] | statusEvent, mTcon[1:0]};
    if (we && (a[31:5] == BASE[31:5])) begin
      case (a[4:2])
        3'd0: mTh = d;
        3'd1: nextTl = d;
        3'd2: nextTcon = {d[2] | statusEvent, d[1:0]};
        3'd3: mLed = d[7:0];
        3'd4: mDigi = d[11:0];
        default: ;
      endcase
    end
    mTl   = nextTl;
    mTcon = nextTcon;
    mTick = mTick + 32'd1;
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] off);
    case (off)
      3'd0:    return mTh;
      3'd1:    return mTl;
      3'd2:    return {29'd0, mTcon};
      3'd3:    return {24'd0, mLed};
      3'd4:    return {20'd0, mDigi};
      3'd5:    return mTick;
      default: return 32'd0;
    endcase
  endfunction

  // This task drives a single bus cycle across exactly one rising edge and leaves the bench at 1 time unit after that edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus.Address    = a;
    bus.Write_data = d;
    bus.MemWrite   = we;
    bus.MemRead    = 1'b0;
    @(posedge clk);
    modelEdge(a, d, we);
    #1;
    bus.MemWrite   = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(32'h0000_0000, 32'h0, 1'b0);
  endtask

  task automatic readCheck(input logic [2:0] off, input logic [31:0] exp, input string tag);
    bus.Address = {BASE[31:5], off, 2'b00};
    bus.MemRead = 1'b1;
    #1;
    checkOutput(tag, bus.Read_data, exp);
    bus.MemRead = 1'b0;
  endtask

  initial begin
    bus.Address    = '0;
    bus.Write_data = '0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    modelReset();
    #2 reset = 1'b1;

    // The first phase checks the reset state and the systick count.
    repeat (10) idleCycle();
    readCheck(3'd5, 32'd10, "systick_after_10");
    for (int i = 0; i < 5; i++) readCheck(3'(i), 32'd0, "reset_reg");
    checkOutput("reset_txd", {31'd0, uart_txd}, 32'd1);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    bus.Address = BASE + 32'd20;
    bus.MemRead = 1'b0;
    #1;
    checkOutput("read_without_memread", bus.Read_data, 32'd0);
    checkOutput("hit_in_window", {31'd0, bus.hit}, 32'd1);

    // The second phase checks the overflow reload and the status bit.
    applyStimulus(BASE + 32'd0, 32'hFFFF_FFF0, 1'b1);
    applyStimulus(BASE + 32'd4, 32'hFFFF_FFFE, 1'b1);
    applyStimulus(BASE + 32'd8, 32'h0000_0003, 1'b1);
    readCheck(3'd1, 32'hFFFF_FFFE, "tl_after_enable");
    idleCycle();
    readCheck(3'd1, 32'hFFFF_FFFF, "tl_before_ovf");
    idleCycle();
    readCheck(3'd1, 32'hFFFF_FFF0, "tl_reloaded");
    readCheck(3'd2, 32'd7, "tcon_status_set");
    checkOutput("irq_after_ovf", {31'd0, irq}, 32'd1);

    // The third phase checks a status-clearing TCON write that lands on an overflow edge.
    applyStimulus(BASE + 32'd8, 32'h3, 1'b1);
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
    applyStimulus(BASE + 32'd4, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(BASE + 32'd8, 32'h3, 1'b1);
    readCheck(3'd2, 32'd7, "tcon_clear_vs_ovf");
    readCheck(3'd1, 32'hFFFF_FFF0, "tl_reload_on_tcon_write");
    checkOutput("irq_kept_on_race", {31'd0, irq}, 32'd1);
    applyStimulus(BASE + 32'd8, 32'h3, 1'b1);
    checkOutput("irq_lone_clear", {31'd0, irq}, 32'd0);

    // A CPU write to TL on the overflow edge wins over the reload.
    applyStimulus(BASE + 32'd4, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(BASE + 32'd4, 32'h0000_1234, 1'b1);
    readCheck(3'd1, 32'h0000_1234, "tl_write_beats_reload");
    readCheck(3'd2, 32'd7, "tcon_status_on_tl_race");
    applyStimulus(BASE + 32'd8, 32'hFFFF_FFF8, 1'b1);
    repeat (3) idleCycle();
    readCheck(3'd1, 32'h0000_1235, "tl_frozen");
    readCheck(3'd2, 32'd0, "tcon_truncated");

    // The fourth phase checks window decode and store truncation.
    applyStimulus(BASE + 32'd12, 32'h0000_003C, 1'b1);
    bus.Address    = BASE + 32'h20;
    bus.Write_data = 32'd5;
    bus.MemWrite   = 1'b1;
    #1;
    checkOutput("hit_outside", {31'd0, bus.hit}, 32'd0);
    applyStimulus(BASE + 32'h20, 32'd5, 1'b1);
    checkOutput("leds_unchanged", {24'd0, leds}, 32'h3C);
    applyStimulus(BASE + 32'h0C, 32'h1234_56A5, 1'b1);
    checkOutput("leds_truncated", {24'd0, leds}, 32'hA5);
    applyStimulus(BASE + 32'h10, 32'hFFFF_FABC, 1'b1);
    checkOutput("digi_truncated", {20'd0, digi}, 32'hABC);
    applyStimulus(BASE + 32'h14, 32'hDEAD_BEEF, 1'b1);
    readCheck(3'd5, mTick, "systick_read_only");

    // The fifth phase applies randomized traffic and checks it against the reference model.
    for (int i = 0; i < 400; i++) begin
      rOff = 3'($urandom_range(0, 7));
`ifdef MMIO_UART_TX_EN
      if (rOff == 3'd6) rOff = 3'd3;
`endif
      rAddr = {BASE[31:5], rOff, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) rAddr = rAddr + 32'h20 * (32'd1 + 32'($urandom_range(0, 3)));
      rData = $urandom;
      if (rOff == 3'd1 && $urandom_range(0, 1) == 1) rData = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if (rOff == 3'd2 && $urandom_range(0, 3) != 0) rData = {29'd0, 1'b0, 2'($urandom_range(1, 3))};
      rWe = ($urandom_range(0, 3) != 0);
      applyStimulus(rAddr, rData, rWe);
      checkOutput("rand_irq", {31'd0, irq}, {31'd0, mTcon[1] & mTcon[2]});
      checkOutput("rand_leds", {24'd0, leds}, {24'd0, mLed});
      checkOutput("rand_digi", {20'd0, digi}, {20'd0, mDigi});
      rOff = 3'($urandom_range(0, 7));
      readCheck(rOff, modelRead(rOff), "rand_read");
    end

    // The sixth phase pulses the asynchronous reset between edges.
    applyStimulus(BASE + 32'h0C, 32'h5A, 1'b1);
    applyStimulus(BASE + 32'h10, 32'h777, 1'b1);
    applyStimulus(BASE + 32'h08, 32'h3, 1'b1);
    applyStimulus(BASE + 32'h04, 32'hFFFF_FFFF, 1'b1);
    idleCycle();
    reset = 1'b0;
    #1;
    checkOutput("async_irq", {31'd0, irq}, 32'd0);
    checkOutput("async_leds", {24'd0, leds}, 32'd0);
    checkOutput("async_digi", {20'd0, digi}, 32'd0);
    readCheck(3'd1, 32'd0, "async_tl");
    readCheck(3'd2, 32'd0, "async_tcon");
    reset = 1'b1;
    modelReset();
    repeat (3) idleCycle();
    readCheck(3'd5, 32'd3, "systick_after_async");

`ifdef MMIO_UART_TX_EN
    // The seventh phase sends one frame and drops a second write issued while the transmitter is busy.
    frame = {1'b1, 8'h55, 1'b0};
    applyStimulus(BASE + 32'h18, 32'h0000_0055, 1'b1);
    for (int k = 0; k < 10 * CLKS; k++) begin
      if (k == 10) applyStimulus(BASE + 32'h18, 32'h0000_00AA, 1'b1);
      else if (k > 0) idleCycle();
      checkOutput("uart_txd_bit", {31'd0, uart_txd}, {31'd0, frame[k / CLKS]});
      readCheck(3'd7, 32'd1, "uart_busy");
    end
    idleCycle();
    readCheck(3'd7, 32'd0, "uart_busy_clear");
    for (int k = 0; k < 50; k++) begin
      idleCycle();
      checkOutput("uart_no_second_frame", {31'd0, uart_txd}, 32'd1);
    end
    readCheck(3'd6, 32'd0, "utx_reads_zero");

    // A reset that arrives mid-frame aborts the frame.
    applyStimulus(BASE + 32'h18, 32'h0000_000F, 1'b1);
    checkOutput("uart_start_bit", {31'd0, uart_txd}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("uart_abort_txd", {31'd0, uart_txd}, 32'd1);
    readCheck(3'd7, 32'd0, "uart_abort_busy");
    reset = 1'b1;
    modelReset();
`else
    applyStimulus(BASE + 32'h18, 32'h0000_0000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      idleCycle();
      checkOutput("no_uart_txd", {31'd0, uart_txd}, 32'd1);
    end
    readCheck(3'd6, 32'd0, "no_uart_utx");
    readCheck(3'd7, 32'd0, "no_uart_ustat");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
